// File: rtl/long_div_controller.sv
// Control sequencer for the shift/subtract long-division datapath.
// Outputs are Mealy strobes decoded from the state register and datapath status.
module long_div_controller (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic divisor_is_zero,
    input  logic divisor_msb,
    input  logic cnt_is_zero,
    input  logic dvsr_less_than_dvnd,
    output logic done,
    output logic error,
    output logic init,
    output logic left,
    output logic right,
    output logic sub
);

    typedef enum logic [2:0] {
        WAIT_FOR_START       = 3'b000,
        CHECK_DIVIDE_BY_ZERO = 3'b001,
        SHIFT_LEFT           = 3'b010,
        SHIFT_RIGHT          = 3'b011,
        ERROR                = 3'b100,
        NO_ERROR             = 3'b101
    } state_t;

    state_t state;
    state_t next_state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_FOR_START;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; everything is held low while reset is asserted
    always_comb begin
        next_state = WAIT_FOR_START;
        done       = 1'b0;
        error      = 1'b0;
        init       = 1'b0;
        left       = 1'b0;
        right      = 1'b0;
        sub        = 1'b0;
        if (!reset) begin
            case (state)
                WAIT_FOR_START: begin
                    if (start) begin
                        next_state = CHECK_DIVIDE_BY_ZERO;
                        init       = 1'b1;
                    end
                end
                CHECK_DIVIDE_BY_ZERO: begin
                    next_state = divisor_is_zero ? ERROR : SHIFT_LEFT;
                end
                SHIFT_LEFT: begin
                    if (divisor_msb) begin
                        next_state = SHIFT_RIGHT;
                    end else begin
                        next_state = SHIFT_LEFT;
                        left       = 1'b1;
                    end
                end
                SHIFT_RIGHT: begin
                    // Subtract decision applies on the last right cycle as well
                    sub = dvsr_less_than_dvnd;
                    if (cnt_is_zero) begin
                        next_state = NO_ERROR;
                    end else begin
                        next_state = SHIFT_RIGHT;
                        right      = 1'b1;
                    end
                end
                ERROR: begin
                    error = 1'b1;
                end
                NO_ERROR: begin
                    done = 1'b1;
                end
                default: begin
                    next_state = WAIT_FOR_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_long_div_controller.sv
// Directed bench for long_div_controller: walks the error, shift and done paths
// and mid-operation reset, comparing strobes and state against hand-derived values.
`timescale 1ns/1ps
module tb_long_div_controller;

    logic clk;
    logic reset;
    logic start;
    logic divisor_is_zero;
    logic divisor_msb;
    logic cnt_is_zero;
    logic dvsr_less_than_dvnd;
    logic done;
    logic error;
    logic init;
    logic left;
    logic right;
    logic sub;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Strobe vector order: {init, left, right, sub, done, error}
    localparam logic [7:0] O_NONE  = 8'b00_000000;
    localparam logic [7:0] O_INIT  = 8'b00_100000;
    localparam logic [7:0] O_LEFT  = 8'b00_010000;
    localparam logic [7:0] O_RIGHT = 8'b00_001000;
    localparam logic [7:0] O_RSUB  = 8'b00_001100;
    localparam logic [7:0] O_SUB   = 8'b00_000100;
    localparam logic [7:0] O_DONE  = 8'b00_000010;
    localparam logic [7:0] O_ERR   = 8'b00_000001;

    long_div_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .divisor_is_zero     (divisor_is_zero),
        .divisor_msb         (divisor_msb),
        .cnt_is_zero         (cnt_is_zero),
        .dvsr_less_than_dvnd (dvsr_less_than_dvnd),
        .done                (done),
        .error               (error),
        .init                (init),
        .left                (left),
        .right               (right),
        .sub                 (sub)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] outs();
        return {2'b00, init, left, right, sub, done, error};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply(input logic st, input logic dz, input logic msb,
                         input logic cz, input logic lt);
        start               = st;
        divisor_is_zero     = dz;
        divisor_msb         = msb;
        cnt_is_zero         = cz;
        dvsr_less_than_dvnd = lt;
        #3;
    endtask

    task automatic expect_cycle(input string tag, input logic [2:0] st,
                                input logic [2:0] nst, input logic [7:0] o);
        chk({tag, ".state"}, 8'(dut.state), 8'(st));
        chk({tag, ".next"},  8'(dut.next_state), 8'(nst));
        chk({tag, ".outs"},  outs(), o);
    endtask

    initial begin
        reset = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        // Start and status inputs ignored while reset is high
        expect_cycle("rst_hold", 3'b000, 3'b000, O_NONE);
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("rst_hold2", 3'b000, 3'b000, O_NONE);

        // Test 1: idle after reset
        tick();
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("idle0", 3'b000, 3'b000, O_NONE);
        tick();
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_cycle("idle1", 3'b000, 3'b000, O_NONE);

        // Test 2: divide by zero path, start ignored in ERROR
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t2_start", 3'b000, 3'b001, O_INIT);
        tick();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle("t2_check", 3'b001, 3'b100, O_NONE);
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("t2_error", 3'b100, 3'b000, O_ERR);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t2_back", 3'b000, 3'b000, O_NONE);

        // Test 3: two left shifts then SHIFT_RIGHT
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t3_start", 3'b000, 3'b001, O_INIT);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_cycle("t3_check", 3'b001, 3'b010, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_cycle("t3_left0", 3'b010, 3'b010, O_LEFT);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t3_left1", 3'b010, 3'b010, O_LEFT);
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_cycle("t3_msb", 3'b010, 3'b011, O_NONE);

        // Test 4: right shifts with and without subtract
        tick();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle("t4_right", 3'b011, 3'b011, O_RIGHT);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("t4_rsub", 3'b011, 3'b011, O_RSUB);

        // Test 5: final cycle with subtract, done pulse, restart
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_cycle("t5_last", 3'b011, 3'b101, O_SUB);
        tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_cycle("t5_done", 3'b101, 3'b000, O_DONE);
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t5_restart", 3'b000, 3'b001, O_INIT);

        // Final right cycle without subtract: quick path CHECK -> msb set at once
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("q_check", 3'b001, 3'b010, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cycle("q_msb", 3'b010, 3'b011, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("q_last", 3'b011, 3'b101, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("q_done", 3'b101, 3'b000, O_DONE);

        // Test 6: reset between edges while in SHIFT_LEFT
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("t6_left", 3'b010, 3'b010, O_LEFT);
        #2;
        reset = 1'b1;
        #2;
        expect_cycle("t6_async", 3'b000, 3'b000, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        expect_cycle("t6_rel", 3'b000, 3'b000, O_NONE);
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_cycle("t6_nodone", 3'b000, 3'b000, O_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
